// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern transmitter with repeat, gap and abort
module serial_pattern_tx #(
    parameter int                       PATTERN_WIDTH   = 4,
    parameter int                       COUNT_WIDTH     = 4,
    parameter logic [PATTERN_WIDTH-1:0] DEFAULT_PATTERN = 4'b1101
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     start,
    input  logic                     use_default,
    input  logic [PATTERN_WIDTH-1:0] pattern,
    input  logic [COUNT_WIDTH-1:0]   repeat_count,
    input  logic [COUNT_WIDTH-1:0]   gap_cycles,
    input  logic                     abort,
    output logic                     w,
    output logic                     w_valid,
    output logic                     frame_start,
    output logic                     busy,
    output logic                     done
);

    localparam int                 BIT_W    = $clog2(PATTERN_WIDTH);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(PATTERN_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] ONE  = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                   state, n_state;
    logic [PATTERN_WIDTH-1:0] pat_lat, n_pat_lat;
    logic [PATTERN_WIDTH-1:0] shreg, n_shreg;
    logic [BIT_W-1:0]         bit_idx, n_bit_idx;
    logic [COUNT_WIDTH-1:0]   frames_left, n_frames_left;
    logic [COUNT_WIDTH-1:0]   gap_len, n_gap_len;
    logic [COUNT_WIDTH-1:0]   gap_cnt, n_gap_cnt;

    always_comb begin
        n_state       = state;
        n_pat_lat     = pat_lat;
        n_shreg       = shreg;
        n_bit_idx     = bit_idx;
        n_frames_left = frames_left;
        n_gap_len     = gap_len;
        n_gap_cnt     = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    n_pat_lat     = use_default ? DEFAULT_PATTERN : pattern;
                    n_shreg       = use_default ? DEFAULT_PATTERN : pattern;
                    n_bit_idx     = '0;
                    n_frames_left = (repeat_count == '0) ? ONE : repeat_count;
                    n_gap_len     = gap_cycles;
                    n_gap_cnt     = '0;
                    n_state       = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    n_state = ST_IDLE;
                end else if (bit_idx == LAST_BIT) begin
                    // frames_left counts the frame just finished, so 1 means last
                    if (frames_left == ONE) begin
                        n_frames_left = '0;
                        n_state       = ST_DONE;
                    end else begin
                        n_frames_left = frames_left - ONE;
                        if (gap_len == '0) begin
                            n_shreg   = pat_lat;
                            n_bit_idx = '0;
                        end else begin
                            n_gap_cnt = gap_len;
                            n_state   = ST_GAP;
                        end
                    end
                end else begin
                    n_shreg   = shreg << 1;
                    n_bit_idx = bit_idx + BIT_W'(1);
                end
            end
            ST_GAP: begin
                if (abort) begin
                    n_state = ST_IDLE;
                end else if (gap_cnt == ONE) begin
                    n_gap_cnt = '0;
                    n_shreg   = pat_lat;
                    n_bit_idx = '0;
                    n_state   = ST_SEND;
                end else begin
                    n_gap_cnt = gap_cnt - ONE;
                end
            end
            ST_DONE: n_state = ST_IDLE;
            default: n_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they describe
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= ST_IDLE;
            pat_lat     <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
            frames_left <= '0;
            gap_len     <= '0;
            gap_cnt     <= '0;
            w           <= 1'b0;
            w_valid     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= n_state;
            pat_lat     <= n_pat_lat;
            shreg       <= n_shreg;
            bit_idx     <= n_bit_idx;
            frames_left <= n_frames_left;
            gap_len     <= n_gap_len;
            gap_cnt     <= n_gap_cnt;
            w           <= (n_state == ST_SEND) ? n_shreg[PATTERN_WIDTH-1] : 1'b0;
            w_valid     <= (n_state == ST_SEND);
            frame_start <= (n_state == ST_SEND) && (n_bit_idx == '0);
            busy        <= (n_state == ST_SEND) || (n_state == ST_GAP);
            done        <= (n_state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - self-checking bench for serial_pattern_tx
module tb_serial_pattern_tx;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       start = 1'b0;
    logic       use_default = 1'b0;
    logic [3:0] pattern = '0;
    logic [3:0] repeat_count = '0;
    logic [3:0] gap_cycles = '0;
    logic       abort = 1'b0;
    logic       w, w_valid, frame_start, busy, done;

    int checks = 0;
    int errors = 0;

    serial_pattern_tx dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .use_default(use_default),
        .pattern(pattern), .repeat_count(repeat_count), .gap_cycles(gap_cycles),
        .abort(abort), .w(w), .w_valid(w_valid), .frame_start(frame_start),
        .busy(busy), .done(done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        ud;
        logic [3:0]  pat;
        logic [3:0]  rep;
        logic [3:0]  gap;
        logic [63:0] bits;
        int          nbits;
        int          done_cyc;
        int          busy_n;
        int          hits;
        int          frames;
    } vec_t;

    // packed as {w, w_valid, frame_start, busy, done}
    logic [4:0] exp_q[$];

    function automatic logic [4:0] outs();
        return {w, w_valid, frame_start, busy, done};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Expected cycle-by-cycle trace built straight from the frame/gap rules
    task automatic build_model(input logic ud, input logic [3:0] pat, input logic [3:0] rep,
                               input logic [3:0] gap);
        logic [3:0] p;
        int frames;
        p = ud ? 4'b1101 : pat;
        frames = (rep == 0) ? 1 : int'(rep);
        exp_q.delete();
        for (int f = 0; f < frames; f++) begin
            for (int i = 3; i >= 0; i--)
                exp_q.push_back({p[i], 1'b1, (i == 3), 1'b1, 1'b0});
            if (f != frames - 1)
                for (int g = 0; g < int'(gap); g++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00001);
        exp_q.push_back(5'b00000);
    endtask

    task automatic run(input logic ud, input logic [3:0] pat, input logic [3:0] rep,
                       input logic [3:0] gap, input bit scramble,
                       output logic [63:0] bits, output int nbits, output int done_cyc,
                       output int busy_n, output int hits, output int fs_n);
        logic [3:0] win;
        bits = '0; nbits = 0; done_cyc = -1; busy_n = 0; hits = 0; fs_n = 0; win = '0;
        build_model(ud, pat, rep, gap);
        @(negedge Clock);
        use_default = ud; pattern = pat; repeat_count = rep; gap_cycles = gap;
        start = 1'b1; abort = 1'b0;
        @(posedge Clock); #1;
        start = 1'b0;
        for (int c = 1; c <= exp_q.size(); c++) begin
            chk($sformatf("trace cycle %0d", c), 64'(outs()), 64'(exp_q[c-1]));
            if (w_valid) begin
                bits = {bits[62:0], w};
                nbits++;
                win = {win[2:0], w};
                if (nbits >= 4 && win == 4'b1101) hits++;
            end
            if (busy) busy_n++;
            if (frame_start) fs_n++;
            if (done && done_cyc < 0) done_cyc = c;
            if (scramble) begin
                use_default = 1'($urandom); pattern = 4'($urandom);
                repeat_count = 4'($urandom); gap_cycles = 4'($urandom);
            end
            if (c != exp_q.size()) begin
                @(posedge Clock); #1;
            end
        end
    endtask

    vec_t        tbl[5];
    logic [63:0] bits;
    int          nbits, done_cyc, busy_n, hits, fs_n;
    logic        seen_done;

    initial begin
        tbl[0] = '{1'b1, 4'h0, 4'd1, 4'd0, 64'b1101, 4, 5, 4, 1, 1};
        tbl[1] = '{1'b1, 4'h6, 4'd3, 4'd0, 64'b110111011101, 12, 13, 12, 3, 3};
        tbl[2] = '{1'b0, 4'b1010, 4'd2, 4'd2, 64'b10101010, 8, 11, 10, 0, 2};
        tbl[3] = '{1'b0, 4'b0011, 4'd0, 4'd5, 64'b0011, 4, 5, 4, 0, 1};
        tbl[4] = '{1'b0, 4'b1000, 4'd2, 4'd1, 64'b10001000, 8, 10, 9, 0, 2};

        repeat (2) @(posedge Clock);
        #1 chk("reset outputs", 64'(outs()), 64'd0);
        @(negedge Clock) Resetn = 1'b1;
        @(posedge Clock); #1 chk("idle after reset", 64'(outs()), 64'd0);

        foreach (tbl[i]) begin
            run(tbl[i].ud, tbl[i].pat, tbl[i].rep, tbl[i].gap, 1'b0,
                bits, nbits, done_cyc, busy_n, hits, fs_n);
            chk($sformatf("vec%0d bits", i), bits, tbl[i].bits);
            chk($sformatf("vec%0d nbits", i), 64'(nbits), 64'(tbl[i].nbits));
            chk($sformatf("vec%0d done cycle", i), 64'(done_cyc), 64'(tbl[i].done_cyc));
            chk($sformatf("vec%0d busy cycles", i), 64'(busy_n), 64'(tbl[i].busy_n));
            chk($sformatf("vec%0d detector hits", i), 64'(hits), 64'(tbl[i].hits));
            chk($sformatf("vec%0d frame_start count", i), 64'(fs_n), 64'(tbl[i].frames));
        end

        // Randomized configs with inputs scrambled mid-transmission; first one forces max repeat
        for (int r = 0; r < 20; r++) begin
            logic [3:0] rp, gp;
            rp = (r == 0) ? 4'd15 : 4'($urandom);
            gp = (r == 0) ? 4'd0 : 4'($urandom_range(0, 3));
            run(1'($urandom), 4'($urandom), rp, gp, 1'b1,
                bits, nbits, done_cyc, busy_n, hits, fs_n);
            chk($sformatf("rand%0d frames", r), 64'(fs_n), 64'((rp == 0) ? 1 : int'(rp)));
        end

        // start held high: done ignores it, next frame only after an IDLE sample
        @(negedge Clock);
        use_default = 1'b1; repeat_count = 4'd1; gap_cycles = 4'd0; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge Clock); #1;
            if (c == 5) chk("held start done", 64'(outs()), 64'b00001);
            if (c == 6) chk("held start idle gap", 64'(outs()), 64'b00000);
            if (c == 7) chk("held start restart", 64'(outs()), 64'b11110);
        end
        start = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge Clock); #1;
            if (done) seen_done = 1'b1;
        end
        chk("held start second done", 64'(seen_done), 64'd1);

        // abort in the second bit of a frame
        @(negedge Clock);
        use_default = 1'b1; repeat_count = 4'd3; start = 1'b1;
        @(posedge Clock); #1 start = 1'b0;
        @(posedge Clock); #1 abort = 1'b1;
        @(posedge Clock); #1 abort = 1'b0;
        chk("abort outputs", 64'(outs()), 64'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clock); #1;
            if (done || busy) seen_done = 1'b1;
        end
        chk("abort no done", 64'(seen_done), 64'd0);

        // abort and start together in IDLE: abort wins
        @(negedge Clock); start = 1'b1; abort = 1'b1;
        @(posedge Clock); #1 start = 1'b0; abort = 1'b0;
        chk("abort beats start", 64'(outs()), 64'd0);

        // asynchronous reset in the middle of a gap
        @(negedge Clock);
        use_default = 1'b0; pattern = 4'b1010; repeat_count = 4'd2; gap_cycles = 4'd3;
        start = 1'b1;
        @(posedge Clock); #1 start = 1'b0;
        repeat (5) @(posedge Clock);
        #1 chk("in gap before reset", 64'(outs()), 64'b00010);
        #2 Resetn = 1'b0;
        #1 chk("async reset outputs", 64'(outs()), 64'd0);
        @(negedge Clock) Resetn = 1'b1;
        run(1'b1, 4'h0, 4'd1, 4'd0, 1'b0, bits, nbits, done_cyc, busy_n, hits, fs_n);
        chk("post-reset frame bits", bits, 64'b1101);
        chk("post-reset done cycle", 64'(done_cyc), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
